// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared types and constants for the operand fetch stage
package operand_fetch_pkg;
    localparam int WIDTH = 16;
    localparam int NUM_REGS = 8;
    localparam int RAW = $clog2(NUM_REGS);
    typedef logic [WIDTH-1:0] word_t;
    typedef logic [RAW-1:0] reg_idx_t;
    typedef enum logic [3:0] {
        F_A         = 4'h0,
        F_A_PLUS_1  = 4'h1,
        F_A_PLUS_B  = 4'h2,
        F_A_MINUS_B = 4'h3,
        F_A_AND_B   = 4'h4,
        F_A_OR_B    = 4'h5,
        F_A_XOR_B   = 4'h6,
        F_A_NOT     = 4'h7,
        F_B         = 4'h8,
        F_SHL       = 4'h9,
        F_SHR       = 4'hA,
        F_ASHR      = 4'hB
    } alu_op_t;
    typedef struct packed {
        word_t    in_a;
        word_t    in_b;
        alu_op_t  opcode;
        reg_idx_t dst;
        logic     wr_en;
    } bundle_t;
    function automatic logic wb_hit(logic en, reg_idx_t wr, reg_idx_t rd);
        return en && (wr == rd);
    endfunction
endpackage

// File: rtl/operand_fetch_reg_file.sv
// operand_fetch_reg_file: architectural registers, two async reads, one sync write
module operand_fetch_reg_file
    import operand_fetch_pkg::*;
(
    input  logic     clock,
    input  logic     reset_L,
    input  logic     wr_en,
    input  reg_idx_t wr_idx,
    input  word_t    wr_data,
    input  reg_idx_t rd_idx_a,
    output word_t    rd_data_a,
    input  reg_idx_t rd_idx_b,
    output word_t    rd_data_b
);
    word_t regs [NUM_REGS];
    // single write port, all entries cleared asynchronously on reset
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_idx] <= wr_data;
        end
    end
    assign rd_data_a = regs[rd_idx_a];
    assign rd_data_b = regs[rd_idx_b];
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: operand read with writeback bypass, scoreboard stalls, registered ALU bundle
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic     clock,
    input  logic     reset_L,
    input  logic     in_valid,
    output logic     in_ready,
    input  alu_op_t  in_op,
    input  reg_idx_t in_srcA,
    input  reg_idx_t in_srcB,
    input  reg_idx_t in_dst,
    input  logic     in_wrEn,
    input  logic     wb_en,
    input  reg_idx_t wb_reg,
    input  word_t    wb_data,
    output logic     out_valid,
    input  logic     out_ready,
    output word_t    out_inA,
    output word_t    out_inB,
    output alu_op_t  out_opcode,
    output reg_idx_t out_dst,
    output logic     out_wrEn
);
    word_t rf_a, rf_b, opnd_a, opnd_b;
    logic [NUM_REGS-1:0] busy, busy_next;
    logic hazard, accept;
    bundle_t bundle;

    operand_fetch_reg_file u_rf (
        .clock    (clock),
        .reset_L  (reset_L),
        .wr_en    (wb_en),
        .wr_idx   (wb_reg),
        .wr_data  (wb_data),
        .rd_idx_a (in_srcA),
        .rd_data_a(rf_a),
        .rd_idx_b (in_srcB),
        .rd_data_b(rf_b)
    );

    // bypassed operands, hazard detection, handshake and next scoreboard
    always_comb begin
        opnd_a = wb_hit(wb_en, wb_reg, in_srcA) ? wb_data : rf_a;
        opnd_b = wb_hit(wb_en, wb_reg, in_srcB) ? wb_data : rf_b;
        hazard = (busy[in_srcA] && !wb_hit(wb_en, wb_reg, in_srcA))
              || (busy[in_srcB] && !wb_hit(wb_en, wb_reg, in_srcB))
              || (in_wrEn && busy[in_dst] && !wb_hit(wb_en, wb_reg, in_dst));
        in_ready = reset_L && (!out_valid || out_ready) && !hazard;
        accept = in_valid && in_ready;
        busy_next = busy;
        if (wb_en) busy_next[wb_reg] = 1'b0;
        if (accept && in_wrEn) busy_next[in_dst] = 1'b1;
    end

    // scoreboard of registers with a write still in flight
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) busy <= '0;
        else busy <= busy_next;
    end

    // output bundle: load on accept, drop valid when consumed, hold otherwise
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            out_valid <= 1'b0;
            bundle <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            bundle <= '{opnd_a, opnd_b, in_op, in_dst, in_wrEn};
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_inA = bundle.in_a;
    assign out_inB = bundle.in_b;
    assign out_opcode = bundle.opcode;
    assign out_dst = bundle.dst;
    assign out_wrEn = bundle.wr_en;
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vectors checked against a behavioural model and literals
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic clock = 1'b0;
    logic reset_L, in_valid, in_ready, in_wrEn, wb_en, out_valid, out_ready, out_wrEn;
    alu_op_t in_op, out_opcode;
    reg_idx_t in_srcA, in_srcB, in_dst, wb_reg, out_dst;
    word_t wb_data, out_inA, out_inB;
    int vectors = 0;
    int miscompares = 0;
    bit go = 1'b0;

    always #5 clock = ~clock;

    operand_fetch dut (
        .clock(clock), .reset_L(reset_L),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_srcA(in_srcA), .in_srcB(in_srcB), .in_dst(in_dst), .in_wrEn(in_wrEn),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inA(out_inA), .out_inB(out_inB), .out_opcode(out_opcode),
        .out_dst(out_dst), .out_wrEn(out_wrEn)
    );

    // behavioural model: register array, pending-write flags, one held bundle
    word_t m_rf [NUM_REGS];
    bit [NUM_REGS-1:0] m_busy;
    bit m_valid;
    bundle_t m_out;

    function automatic word_t m_read(reg_idx_t r);
        return (wb_en && wb_reg == r) ? wb_data : m_rf[r];
    endfunction

    function automatic bit m_pending(reg_idx_t r);
        return m_busy[r] && !(wb_en && wb_reg == r);
    endfunction

    function automatic bit m_ready();
        return reset_L && (!m_valid || out_ready)
            && !(m_pending(in_srcA) || m_pending(in_srcB) || (in_wrEn && m_pending(in_dst)));
    endfunction

    always @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_REGS; i++) m_rf[i] <= '0;
            m_busy <= '0;
            m_valid <= 1'b0;
            m_out <= '0;
        end else begin
            if (in_valid && m_ready()) begin
                m_valid <= 1'b1;
                m_out <= '{m_read(in_srcA), m_read(in_srcB), in_op, in_dst, in_wrEn};
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
            if (wb_en) begin
                m_rf[wb_reg] <= wb_data;
                m_busy[wb_reg] <= 1'b0;
            end
            if (in_valid && m_ready() && in_wrEn) m_busy[in_dst] <= 1'b1;
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // every cycle: handshake and bundle against the model
    always @(negedge clock) begin
        if (go) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, m_ready()});
            check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (m_valid) begin
                check("out_inA", {16'd0, out_inA}, {16'd0, m_out.in_a});
                check("out_inB", {16'd0, out_inB}, {16'd0, m_out.in_b});
                check("out_opcode", {28'd0, out_opcode}, {28'd0, m_out.opcode});
                check("out_dst", {29'd0, out_dst}, {29'd0, m_out.dst});
                check("out_wrEn", {31'd0, out_wrEn}, {31'd0, m_out.wr_en});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        wb_en = 1'b0;
    endtask

    task automatic issue(alu_op_t op, reg_idx_t a, reg_idx_t b, reg_idx_t d, logic w);
        in_valid = 1'b1;
        in_op = op;
        in_srcA = a;
        in_srcB = b;
        in_dst = d;
        in_wrEn = w;
    endtask

    task automatic wb(reg_idx_t r, word_t d);
        wb_en = 1'b1;
        wb_reg = r;
        wb_data = d;
    endtask

    initial begin
        reset_L = 1'b0;
        in_valid = 1'b0; in_op = F_A; in_srcA = '0; in_srcB = '0; in_dst = '0; in_wrEn = 1'b0;
        wb_en = 1'b0; wb_reg = '0; wb_data = '0; out_ready = 1'b1;
        tick();
        tick();
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_inA", {16'd0, out_inA}, 32'd0);
        check("rst out_inB", {16'd0, out_inB}, 32'd0);
        check("rst out_opcode", {28'd0, out_opcode}, {28'd0, F_A});
        check("rst out_dst", {29'd0, out_dst}, 32'd0);
        check("rst out_wrEn", {31'd0, out_wrEn}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd0);
        reset_L = 1'b1;
        go = 1'b1;
        // writeback to an idle register, then read it twice
        wb(3, 16'h1234);
        tick();
        wb_en = 1'b0;
        issue(F_A_PLUS_B, 3, 3, 5, 1'b1);
        #1 check("t1 in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("t1 out_valid", {31'd0, out_valid}, 32'd1);
        check("t1 out_inA", {16'd0, out_inA}, 32'h1234);
        check("t1 out_inB", {16'd0, out_inB}, 32'h1234);
        check("t1 out_dst", {29'd0, out_dst}, 32'd5);
        check("t1 out_opcode", {28'd0, out_opcode}, {28'd0, F_A_PLUS_B});
        in_srcA = 5; in_srcB = 0; in_wrEn = 1'b0;
        #1 check("t1 busy r5", {31'd0, in_ready}, 32'd0);
        tick();
        // same-cycle writeback bypass
        wb(2, 16'h00FF);
        issue(F_A, 2, 3, 6, 1'b0);
        #1 check("t2 in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        idle();
        check("t2 out_inA", {16'd0, out_inA}, 32'h00FF);
        check("t2 out_inB", {16'd0, out_inB}, 32'h1234);
        // read-after-write stall until writeback
        issue(F_A, 0, 0, 4, 1'b1);
        tick();
        issue(F_A_PLUS_B, 0, 4, 7, 1'b0);
        #1 check("t3 raw stall", {31'd0, in_ready}, 32'd0);
        tick();
        check("t3 raw stall 2", {31'd0, in_ready}, 32'd0);
        wb(4, 16'hBEEF);
        #1 check("t3 wb release", {31'd0, in_ready}, 32'd1);
        tick();
        idle();
        check("t3 out_valid", {31'd0, out_valid}, 32'd1);
        check("t3 out_inB", {16'd0, out_inB}, 32'hBEEF);
        // backpressure then back-to-back accepts
        out_ready = 1'b0;
        issue(F_A_MINUS_B, 2, 3, 6, 1'b0);
        repeat (3) begin
            #1 check("t4 held in_ready", {31'd0, in_ready}, 32'd0);
            check("t4 held out_inB", {16'd0, out_inB}, 32'hBEEF);
            check("t4 held out_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1 check("t4 release", {31'd0, in_ready}, 32'd1);
        tick();
        check("t4 b2b valid 1", {31'd0, out_valid}, 32'd1);
        check("t4 b2b inA 1", {16'd0, out_inA}, 32'h00FF);
        check("t4 b2b inB 1", {16'd0, out_inB}, 32'h1234);
        issue(F_A_PLUS_B, 3, 2, 6, 1'b0);
        tick();
        check("t4 b2b valid 2", {31'd0, out_valid}, 32'd1);
        check("t4 b2b inA 2", {16'd0, out_inA}, 32'h1234);
        check("t4 b2b inB 2", {16'd0, out_inB}, 32'h00FF);
        idle();
        tick();
        // write-after-write stall, then same-edge clear and set
        issue(F_A, 0, 0, 1, 1'b1);
        tick();
        #1 check("t5 waw stall", {31'd0, in_ready}, 32'd0);
        tick();
        wb(1, 16'h5555);
        #1 check("t5 same-edge", {31'd0, in_ready}, 32'd1);
        tick();
        idle();
        check("t5 out_dst", {29'd0, out_dst}, 32'd1);
        check("t5 out_wrEn", {31'd0, out_wrEn}, 32'd1);
        in_srcA = 1; in_srcB = 0; in_wrEn = 1'b0;
        #1 check("t5 busy r1", {31'd0, in_ready}, 32'd0);
        // asynchronous reset during a stall with a held bundle
        out_ready = 1'b0;
        issue(F_A, 3, 1, 5, 1'b1);
        tick();
        #1 reset_L = 1'b0;
        #1 check("t6 async out_valid", {31'd0, out_valid}, 32'd0);
        check("t6 async in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clock);
        #1 reset_L = 1'b1;
        #1 check("t6 busy cleared", {31'd0, in_ready}, 32'd1);
        tick();
        check("t6 out_valid", {31'd0, out_valid}, 32'd1);
        check("t6 rf cleared A", {16'd0, out_inA}, 32'd0);
        check("t6 rf cleared B", {16'd0, out_inB}, 32'd0);
        check("t6 out_dst", {29'd0, out_dst}, 32'd5);
        idle();
        out_ready = 1'b1;
        tick();
        tick();
        go = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
